// File: rtl/quad_decoder_if.sv
// Increment/decrement command link from the quadrature decoder to the up/down counter.
// The decoder drives it through the master modport; the counter listens on slave.
interface quad_decoder_if;
  logic increment;
  logic decrement;

  modport master (output increment, output decrement);
  modport slave  (input  increment, input  decrement);
endinterface

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: 2-flop synchronizer, optional glitch filter (QUAD_FILTER_EN), step/error FSM.
// Emits one-cycle increment/decrement pulses and a saturating tally of illegal two-phase jumps.
module quad_decoder #(
  parameter int FILTER_LEN = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           a,
  input  logic           b,
  quad_decoder_if.master step,
  output logic           error,
  output logic           dir,
  output logic [3:0]     err_cnt
);

  typedef enum logic {INIT, TRACK} state_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} step_t;

  state_t     state;
  logic [1:0] init_cnt;
  logic [1:0] pair_p0;
  logic [1:0] pair_p1;
  logic [1:0] accepted;
  logic [1:0] prev;
  logic       inc_q;
  logic       dec_q;

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("quad_decoder: FILTER_LEN must lie in 1..15");
  end

  // Classify a transition of the {a,b} pair on the 00-01-11-10 cycle.
  function automatic step_t classify(input logic [1:0] from, input logic [1:0] to);
    step_t kind;
    kind = STEP_ERR;
    if (from == to) begin
      kind = STEP_NONE;
    end else begin
      case ({from, to})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: kind = STEP_FWD;
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: kind = STEP_REV;
        default:                                kind = STEP_ERR;
      endcase
    end
    return kind;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer for both phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_p0 <= 2'b00;
      pair_p1 <= 2'b00;
    end else begin
      pair_p0 <= {a, b};
      pair_p1 <= pair_p0;
    end
  end

`ifdef QUAD_FILTER_EN
  localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

  logic [1:0] flt_acc;
  logic [3:0] flt_cnt [2];

  // Filter stage: a phase must differ from its accepted level for FILTER_LEN
  // consecutive cycles. During INIT the filter simply follows the synchronizer
  // so the level present at reset release is taken as the starting point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_acc    <= 2'b00;
      flt_cnt[0] <= 4'd0;
      flt_cnt[1] <= 4'd0;
    end else if (state == INIT) begin
      flt_acc    <= pair_p1;
      flt_cnt[0] <= 4'd0;
      flt_cnt[1] <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pair_p1[i] == flt_acc[i]) begin
          flt_cnt[i] <= 4'd0;
        end else if (flt_cnt[i] == FLT_LAST) begin
          flt_acc[i] <= pair_p1[i];
          flt_cnt[i] <= 4'd0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign accepted = flt_acc;
`else
  assign accepted = pair_p1;
`endif

  // Decode stage: compare accepted pair with prev; all outputs registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= 2'd0;
      prev     <= 2'b00;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      error    <= 1'b0;
      dir      <= 1'b0;
      err_cnt  <= 4'd0;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      error <= 1'b0;
      case (state)
        INIT: begin
          if (init_cnt == 2'd2) begin
            prev  <= pair_p1;
            state <= TRACK;
          end else begin
            init_cnt <= init_cnt + 2'd1;
          end
        end
        TRACK: begin
          prev <= accepted;
          case (classify(prev, accepted))
            STEP_FWD: begin
              inc_q <= 1'b1;
              dir   <= 1'b1;
            end
            STEP_REV: begin
              dec_q <= 1'b1;
              dir   <= 1'b0;
            end
            STEP_ERR: begin
              error   <= 1'b1;
              err_cnt <= sat_inc(err_cnt);
            end
            default: ;
          endcase
        end
        default: state <= INIT;
      endcase
    end
  end

  assign step.increment = inc_q;
  assign step.decrement = dec_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: per-cycle reference model plus directed vector table and corner sequences.
module tb_quad_decoder;
  localparam int FL = 3;
`ifdef QUAD_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int LAT = 2 + (FILT ? FL : 0);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a = 1'b1;
  logic       b = 1'b1;
  logic       error;
  logic       dir;
  logic [3:0] err_cnt;

  quad_decoder_if u_if ();

  quad_decoder #(.FILTER_LEN(FL)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .step    (u_if),
    .error   (error),
    .dir     (dir),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: hist[e] is the {a,b} level seen at edge e after release.
  logic [1:0] hist [$];
  int         e;
  logic [1:0] m_prev;
  logic [1:0] facc;
  logic       x_inc, x_dec, x_err, x_dir;
  logic [3:0] x_cnt;
  int         cnt_inc = 0, cnt_dec = 0, cnt_err = 0;

  typedef struct {
    logic [1:0] seq [4];
    int         n_inc;
    int         n_dec;
    int         n_err;
    logic       dir_after;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", name, e, act, exp);
    end
  endtask

  function automatic int pos_of(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] lvl_of(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(2'b00);
    e = 0;
    m_prev = 2'b00;
    facc = 2'b00;
    x_inc = 0; x_dec = 0; x_err = 0; x_dir = 0; x_cnt = 4'd0;
  endtask

  // One clock: record the sampled level, advance the model, compare on the falling edge.
  task automatic tick();
    logic [1:0] cur;
    logic [1:0] nf;
    int         d;
    @(posedge clk);
    e++;
    hist.push_back({a, b});
    x_inc = 0; x_dec = 0; x_err = 0;
    if (e == 3) begin
      m_prev = hist[1];
      facc   = hist[1];
    end else if (e >= 4) begin
      cur = FILT ? facc : hist[e-2];
      d = (pos_of(cur) - pos_of(m_prev) + 4) % 4;
      if (d == 1) begin x_inc = 1; x_dir = 1; end
      else if (d == 3) begin x_dec = 1; x_dir = 0; end
      else if (d == 2) begin x_err = 1; x_cnt = (x_cnt == 4'hF) ? x_cnt : x_cnt + 4'd1; end
      m_prev = cur;
      nf = facc;
      for (int i = 0; i < 2; i++) begin
        bit ok;
        ok = 1'b1;
        for (int j = 0; j < FL; j++) begin
          logic [1:0] h;
          if (e - j < 4) ok = 1'b0;
          else begin
            h = hist[e-j-2];
            if (h[i] == facc[i]) ok = 1'b0;
          end
        end
        if (ok) nf[i] = ~facc[i];
      end
      facc = nf;
    end
    @(negedge clk);
    check("cycle", {u_if.increment, u_if.decrement, error, dir, err_cnt},
          {x_inc, x_dec, x_err, x_dir, x_cnt});
    cnt_inc += int'(u_if.increment);
    cnt_dec += int'(u_if.decrement);
    cnt_err += int'(error);
  endtask

  task automatic do_reset(input logic na, input logic nb);
    @(negedge clk);
    reset = 1'b0;
    a = na;
    b = nb;
    #1;
    check("reset_out", {u_if.increment, u_if.decrement, error, dir, err_cnt}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic run_vec(input int idx);
    int si, sd, se;
    si = cnt_inc; sd = cnt_dec; se = cnt_err;
    for (int k = 0; k < 4; k++) begin
      {a, b} = tbl[idx].seq[k];
      repeat (4) tick();
    end
    repeat (4) tick();
    check($sformatf("vec%0d_inc", idx), cnt_inc - si, tbl[idx].n_inc);
    check($sformatf("vec%0d_dec", idx), cnt_dec - sd, tbl[idx].n_dec);
    check($sformatf("vec%0d_err", idx), cnt_err - se, tbl[idx].n_err);
    check($sformatf("vec%0d_dir", idx), dir, tbl[idx].dir_after);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int si, sd, se, p;
    tbl[0] = '{seq: '{2'b11, 2'b10, 2'b00, 2'b01}, n_inc: 4, n_dec: 0, n_err: 0, dir_after: 1'b1};
    tbl[1] = '{seq: '{2'b00, 2'b10, 2'b11, 2'b01}, n_inc: 0, n_dec: 4, n_err: 0, dir_after: 1'b0};
    tbl[2] = '{seq: '{2'b11, 2'b01, 2'b11, 2'b10}, n_inc: 3, n_dec: 1, n_err: 0, dir_after: 1'b1};
    tbl[3] = '{seq: '{2'b01, 2'b10, 2'b01, 2'b11}, n_inc: 1, n_dec: 0, n_err: 3, dir_after: 1'b1};
    tbl[4] = '{seq: '{2'b01, 2'b11, 2'b01, 2'b00}, n_inc: 1, n_dec: 3, n_err: 0, dir_after: 1'b0};
    model_reset();

    // Reset release with both phases high: nothing may be emitted.
    do_reset(1'b1, 1'b1);
    repeat (12) tick();
    check("init11_inc", cnt_inc, 0);
    check("init11_dec", cnt_dec, 0);
    check("init11_err", cnt_err, 0);
    check("init11_cnt", err_cnt, 0);
    check("init11_dir", dir, 0);

    // First-step latency from 00.
    do_reset(1'b0, 1'b0);
    repeat (6) tick();
    {a, b} = 2'b01;
    for (int t = 0; t <= LAT + 1; t++) begin
      tick();
      check($sformatf("latency_t%0d", t), u_if.increment, (t == LAT));
    end

    for (int v = 0; v < 5; v++) run_vec(v);

    // Twenty jumps starting from 11, then a legal step out of 11.
    do_reset(1'b1, 1'b1);
    repeat (6) tick();
    si = cnt_inc; sd = cnt_dec; se = cnt_err;
    for (int k = 0; k < 20; k++) begin
      {a, b} = ~{a, b};
      repeat (4) tick();
    end
    repeat (4) tick();
    check("jump_err", cnt_err - se, 20);
    check("jump_sat", err_cnt, 15);
    check("jump_inc", cnt_inc - si, 0);
    check("jump_dec", cnt_dec - sd, 0);
    {a, b} = 2'b10;
    repeat (LAT + 2) tick();
    check("after_jump_inc", cnt_inc - si, 1);
    check("after_jump_dir", dir, 1);

    // Random walk against the model.
    p = pos_of({a, b});
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) p = p + 1;
      else if (r < 6) p = p + 3;
      else if (r < 8) p = p + 2;
      {a, b} = lvl_of(p);
      repeat ($urandom_range(1, 6)) tick();
    end
    repeat (8) tick();

    // Asynchronous reset while a pulse is high.
    p = pos_of({a, b}) + 1;
    {a, b} = lvl_of(p);
    repeat (LAT + 1) tick();
    check("pulse_pending", u_if.increment, 1);
    #1 reset = 1'b0;
    #1;
    check("async_reset", {u_if.increment, u_if.decrement, error, dir, err_cnt}, 8'h00);
    p = p + 1;
    {a, b} = lvl_of(p);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    si = cnt_inc; sd = cnt_dec; se = cnt_err;
    repeat (8) tick();
    check("post_reset_quiet", (cnt_inc - si) + (cnt_dec - sd) + (cnt_err - se), 0);
    p = p + 1;
    {a, b} = lvl_of(p);
    repeat (LAT + 2) tick();
    check("post_reset_inc", cnt_inc - si, 1);

`ifdef QUAD_FILTER_EN
    // Short glitch on a must vanish; a held change decodes at LAT.
    repeat (4) tick();
    si = cnt_inc; sd = cnt_dec; se = cnt_err;
    a = ~a;
    repeat (2) tick();
    a = ~a;
    repeat (10) tick();
    check("glitch_quiet", (cnt_inc - si) + (cnt_dec - sd) + (cnt_err - se), 0);
    p = pos_of({a, b}) + 1;
    {a, b} = lvl_of(p);
    for (int t = 0; t <= LAT + 1; t++) begin
      tick();
      check($sformatf("flt_latency_t%0d", t), u_if.increment, (t == LAT));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature encoder front end that converts two asynchronous phase inputs (`a`, `b`) into single-cycle `increment` / `decrement` command pulses. It is the producing end of the increment/decrement interface consumed by the up/down counter. It also reports illegal two-phase jumps and keeps a saturating error tally. Decoding is x4: every legal edge on either phase yields exactly one pulse.

## Interface
- `FILTER_LEN`, 3: consecutive stable cycles required before a phase change is accepted (only with the filter compiled in; legal range 1–15).
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; one clock domain only.
- `a`  input  1  phase A; asynchronous to `clk`.
- `b`  input  1  phase B; asynchronous to `clk`.
- `increment`  output  1  one-cycle pulse per forward step.
- `decrement`  output  1  one-cycle pulse per reverse step.
- `error`  output  1  one-cycle pulse when both phases change in one accepted sample.
- `dir`  output  1  last legal direction: 1 = forward, 0 = reverse.
- `err_cnt`  output  4  saturating count of `error` pulses.

## Operation
- Input path: each phase passes through a 2-flop synchronizer, then the optional filter, giving the accepted phase pair `{a,b}`.
- Forward sequence: 00→01→11→10→00. Reverse is the same sequence in the opposite order.
- State machine:
  - INIT (entered on reset): the synchronizers fill for 2 cycles. On the 3rd cycle the accepted pair is loaded into `prev` and the FSM moves to TRACK. No pulses are issued in INIT, whatever the input levels.
  - TRACK: each cycle, the accepted pair is compared with `prev`, then `prev` is updated.
- TRACK decode rules:
  - Equal pair: no pulse.
  - Forward neighbour: `increment`=1, `dir`←1.
  - Reverse neighbour: `decrement`=1, `dir`←0.
  - Both bits differ: `error`=1, no inc/dec pulse, `dir` unchanged, `prev` still takes the new pair (resynchronizes).
- `increment` and `decrement` are never high together. `error` never coincides with either.
- `err_cnt` increments on each `error` and holds at 15.
- Reset values: `increment`=0, `decrement`=0, `error`=0, `dir`=0, `err_cnt`=0, `prev`=00, synchronizers=00, filter counters=0, FSM=INIT.
- Reset asserted mid-operation clears everything immediately (asynchronously) and aborts any pending pulse. After release, the INIT sequence repeats.

## Timing
- All outputs are registered.
- Without filter: a phase level first sampled at rising edge k is in sync stage 2 after edge k+1. The pulse is registered at edge k+2 and is high for exactly the cycle between edges k+2 and k+3.
- With filter: add `FILTER_LEN` cycles to that latency.
- Maximum legal step rate: one edge per clock (filter off) or one per `FILTER_LEN`+1 clocks (filter on). Faster edges may alias into `error` or be lost; this is defined behaviour, not a fault.
- Back-to-back legal steps give pulses on consecutive cycles with no gap.
- A direction reversal pulses the opposite output on the very next accepted step.
- `err_cnt` updates in the same edge that sets `error`.

## Configuration
- `QUAD_FILTER_EN` defined: a per-phase glitch filter sits after the synchronizer.
  - Each phase has a 4-bit stability counter.
  - The counter resets whenever the synchronized value equals the accepted value, or changes between cycles.
  - The accepted value takes the new level once the counter reaches `FILTER_LEN`.
  - Pulses shorter than `FILTER_LEN` cycles are discarded.
- `QUAD_FILTER_EN` not defined: the synchronizer output is the accepted value directly. `FILTER_LEN` is ignored.

## Test plan
- Reset release with `a`=1, `b`=1 held -> no `increment`/`decrement`/`error` in INIT or afterwards; `err_cnt`=0, `dir`=0.
- Forward drive 00→01→11→10→00, each level held 4 clocks (filter off) -> exactly 4 `increment` pulses, each 1 cycle wide, first pulse 3 edges after the first change; `dir`=1.
- Reverse drive 00→10→11→01→00 -> exactly 4 `decrement` pulses; `dir`=0; no `increment`.
- Jump 00→11, 20 times -> 20 `error` pulses, `err_cnt` saturates at 15, no inc/dec pulses, next legal step from 11 decodes correctly.
- Filter on, `FILTER_LEN`=3: 2-cycle glitch on `a` -> no pulse; 4-cycle level change -> one pulse at latency 3+3 edges.
- Reset asserted during a forward sequence -> all outputs 0 immediately, `err_cnt`=0; after release, INIT repeats and decoding resumes from the current levels with no spurious pulse.
